// File: rtl/uart_rx_os16_if.sv
// Receive-side bundle of the 16x-oversampling UART receiver: serial line in, framed byte and status out.
interface uart_rx_os16_if;
   logic       rxd;
   logic [7:0] data_o;
   logic       data_valid;
   logic       frame_err;
   logic       busy;

   // Receiver side: consumes the line, produces the byte and its strobes.
   modport slave (
      input  rxd,
      output data_o, data_valid, frame_err, busy
   );

   // Line driver / byte consumer side.
   modport master (
      output rxd,
      input  data_o, data_valid, frame_err, busy
   );
endinterface

// File: rtl/uart_rx_os16.sv
// 8N1 UART receiver on the system clock: 16x prescaler, start-glitch rejection,
// 3-sample majority per bit and stop-bit framing check.
module uart_rx_os16 #(
   parameter int CLK_FREQ  = 100_000_000,
   parameter int BAUD_RATE = 9600
) (
   input  logic          clk,
   input  logic          rst_n,
   uart_rx_os16_if.slave bus
);
   localparam int DIV = CLK_FREQ / (BAUD_RATE * 16);
   localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

   state_t        state, state_nxt;
   logic [1:0]    sync_q;
   logic          rx_s;
   logic [PW-1:0] prescale;
   logic [3:0]    tick_cnt;
   logic [2:0]    bit_idx, bit_idx_nxt;
   logic [7:0]    shift, shift_nxt;
   logic          s7, s8;
   logic          tick, mid, last, majority;
   logic          valid_nxt, ferr_nxt;

   assign rx_s     = sync_q[1];
   assign tick     = (state != IDLE) && (prescale == PW'(DIV - 1));
   assign mid      = tick && (tick_cnt == 4'd9);
   assign last     = tick && (tick_cnt == 4'd15);
   // Third vote is the live sample at tick 9, so the bit resolves without an extra cycle.
   assign majority = (s7 & s8) | (s7 & rx_s) | (s8 & rx_s);
   assign bus.busy = (state != IDLE);

   always_comb begin
      // NOTE: every output of this block gets a default first so no path leaves one unassigned and infers a latch.
      state_nxt   = state;
      bit_idx_nxt = bit_idx;
      shift_nxt   = shift;
      valid_nxt   = 1'b0;
      ferr_nxt    = 1'b0;
      case (state)
         IDLE:      if (!rx_s) state_nxt = START;
         START: begin
            if (mid && majority) state_nxt = IDLE;
            else if (last) begin
               state_nxt   = DATA;
               bit_idx_nxt = 3'd0;
            end
         end
         DATA: begin
            if (mid) shift_nxt = {majority, shift[7:1]};
            if (last) begin
               if (bit_idx == 3'd7) state_nxt = STOP;
               else bit_idx_nxt = bit_idx + 3'd1;
            end
         end
         STOP: begin
            // Leaving at mid-stop leaves half a bit to catch a back-to-back start edge.
            if (mid) begin
               if (majority) begin
                  valid_nxt = 1'b1;
                  state_nxt = IDLE;
               end else begin
                  ferr_nxt  = 1'b1;
                  state_nxt = WAIT_HIGH;
               end
            end
         end
         WAIT_HIGH: if (rx_s) state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         sync_q         <= 2'b11;
         prescale       <= '0;
         tick_cnt       <= 4'd0;
         bit_idx        <= 3'd0;
         shift          <= 8'd0;
         s7             <= 1'b0;
         s8             <= 1'b0;
         bus.data_o     <= 8'd0;
         bus.data_valid <= 1'b0;
         bus.frame_err  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values, independent of statement order.
         state   <= state_nxt;
         sync_q  <= {sync_q[0], bus.rxd};
         bit_idx <= bit_idx_nxt;
         shift   <= shift_nxt;

         // Held at zero while idle so the tick phase starts from the start edge.
         if (state == IDLE)                     prescale <= '0;
         else if (prescale == PW'(DIV - 1))     prescale <= '0;
         else                                   prescale <= prescale + PW'(1);

         if (state_nxt != state) tick_cnt <= 4'd0;
         else if (tick)          tick_cnt <= tick_cnt + 4'd1;

         if (tick && tick_cnt == 4'd7) s7 <= rx_s;
         if (tick && tick_cnt == 4'd8) s8 <= rx_s;

         if (valid_nxt) bus.data_o <= shift;
         bus.data_valid <= valid_nxt;
         bus.frame_err  <= ferr_nxt;
      end
   end
endmodule

// File: tb/tb_uart_rx_os16.sv
// Bench for uart_rx_os16: directed scenarios plus random frames scored against an expected-byte model.
module tb_uart_rx_os16;
   localparam int  DIV    = 8;
   localparam real BP     = 16.0 * DIV;          // clk cycles per nominal bit
   localparam int  SP_OFF = 16 * DIV / 2 - DIV / 2;
   localparam int  NOM    = 9 * 16 * DIV + 9 * DIV + 3;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   uart_rx_os16_if bus ();

   uart_rx_os16 #(.CLK_FREQ(640_000), .BAUD_RATE(5_000)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int         errors = 0;
   int         checks = 0;
   int         cyc    = 0;
   int         fall_cyc = 0;
   logic [7:0] dv_q[$];
   int         dv_cyc_q[$];
   int         ferr_n = 0;
   int         both_n = 0;
   bit         busy_seen = 1'b0;
   logic [7:0] last_good = 8'h00;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (bus.data_valid) begin
         dv_q.push_back(bus.data_o);
         dv_cyc_q.push_back(cyc);
      end
      if (bus.frame_err) ferr_n++;
      if (bus.data_valid && bus.frame_err) both_n++;
      if (bus.busy) busy_seen = 1'b1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_obs();
      dv_q.delete();
      dv_cyc_q.delete();
      ferr_n    = 0;
      busy_seen = 1'b0;
   endtask

   function automatic logic [31:0] pop_byte();
      if (dv_q.size() == 0) return 32'hFFFF_FFFF;
      return {24'd0, dv_q.pop_front()};
   endfunction

   // Drives one frame at bp clk/bit; optional one-tick inverted spike on frame bit spike_bit,
   // optional early return after abort_at cycles. Runs in the posedge+1 phase.
   task automatic send_frame(input logic [7:0] b, input real bp, input logic stop_val,
                             input int spike_bit, input int abort_at);
      logic [9:0] bits;
      int t, edge_t, bit_start;
      bits     = {stop_val, b, 1'b0};
      t        = 0;
      fall_cyc = cyc;
      for (int i = 0; i < 10; i++) begin
         edge_t    = $rtoi((i + 1) * bp + 0.5);
         bit_start = t;
         while (t < edge_t) begin
            if (t == abort_at) return;
            bus.rxd = (i == spike_bit && t >= bit_start + SP_OFF && t < bit_start + SP_OFF + DIV)
                      ? ~bits[i] : bits[i];
            step();
            t++;
         end
      end
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      while (bus.busy && n < 5000) begin
         step();
         n++;
      end
      check({"idle_", tag}, {31'd0, bus.busy}, 32'd0);
   endtask

   task automatic expect_byte(input string tag, input logic [7:0] b);
      check({tag, "_count"}, dv_q.size(), 1);
      check({tag, "_data"}, pop_byte(), {24'd0, b});
      check({tag, "_ferr"}, ferr_n, 0);
      last_good = b;
   endtask

   initial begin
      int         lat, gap, pct;
      logic [7:0] rb;
      logic       rstop;

      bus.rxd = 1'b1;
      repeat (3) step();
      check("rst_data_o", {24'd0, bus.data_o}, 32'd0);
      check("rst_valid", {31'd0, bus.data_valid}, 32'd0);
      check("rst_ferr", {31'd0, bus.frame_err}, 32'd0);
      check("rst_busy", {31'd0, bus.busy}, 32'd0);
      rst_n = 1'b1;
      repeat (4) step();

      // Single nominal byte with latency window.
      clear_obs();
      send_frame(8'h55, BP, 1'b1, -1, -1);
      wait_idle("t1");
      lat = (dv_cyc_q.size() > 0) ? dv_cyc_q[0] - fall_cyc : 0;
      check("t1_latency_window", {31'd0, (lat >= NOM - DIV) && (lat <= NOM + DIV)}, 32'd1);
      expect_byte("t1", 8'h55);

      // Back-to-back frames, no idle gap.
      clear_obs();
      send_frame(8'hA5, BP, 1'b1, -1, -1);
      send_frame(8'h3C, BP, 1'b1, -1, -1);
      wait_idle("t2");
      check("t2_count", dv_q.size(), 2);
      gap = (dv_cyc_q.size() >= 2) ? dv_cyc_q[1] - dv_cyc_q[0] : 0;
      check("t2_spacing", {31'd0, (gap >= 10 * 16 * DIV - DIV) && (gap <= 10 * 16 * DIV + DIV)}, 32'd1);
      check("t2_first", pop_byte(), 32'hA5);
      check("t2_second", pop_byte(), 32'h3C);
      last_good = 8'h3C;

      // Short low glitch (~0.2 bit) on an idle line.
      clear_obs();
      bus.rxd = 1'b0;
      repeat (25) step();
      bus.rxd = 1'b1;
      wait_idle("t3");
      check("t3_busy_pulsed", {31'd0, busy_seen}, 32'd1);
      check("t3_no_valid", dv_q.size(), 0);
      check("t3_no_ferr", ferr_n, 0);

      // Low stop bit, line held low 3 more bit-times, then a good byte.
      clear_obs();
      send_frame(8'h81, BP, 1'b0, -1, -1);
      repeat (3 * 16 * DIV) step();
      check("t4_ferr_once", ferr_n, 1);
      check("t4_no_valid", dv_q.size(), 0);
      check("t4_busy_held", {31'd0, bus.busy}, 32'd1);
      check("t4_data_held", {24'd0, bus.data_o}, {24'd0, last_good});
      bus.rxd = 1'b1;
      wait_idle("t4");
      repeat (16 * DIV) step();
      clear_obs();
      send_frame(8'h42, BP, 1'b1, -1, -1);
      wait_idle("t4b");
      expect_byte("t4b", 8'h42);

      // One-tick inverted spike centred on data bit 4 (frame bit 5).
      clear_obs();
      send_frame(8'hF0, BP, 1'b1, 5, -1);
      wait_idle("t5");
      expect_byte("t5", 8'hF0);

      // Reset in the middle of data bit 3.
      clear_obs();
      send_frame(8'hC3, BP, 1'b1, -1, $rtoi(4.5 * BP));
      rst_n = 1'b0;
      #1;
      check("t6_rst_data_o", {24'd0, bus.data_o}, 32'd0);
      check("t6_rst_valid", {31'd0, bus.data_valid}, 32'd0);
      check("t6_rst_ferr", {31'd0, bus.frame_err}, 32'd0);
      check("t6_rst_busy", {31'd0, bus.busy}, 32'd0);
      bus.rxd = 1'b1;
      repeat (20) step();
      rst_n = 1'b1;
      repeat (4) step();
      clear_obs();
      send_frame(8'h5A, BP, 1'b1, -1, -1);
      wait_idle("t6");
      expect_byte("t6", 8'h5A);

      // Baud mismatch +2% / -2%.
      clear_obs();
      send_frame(8'h55, BP * 1.02, 1'b1, -1, -1);
      wait_idle("t7s");
      expect_byte("t7_slow", 8'h55);
      clear_obs();
      send_frame(8'h55, BP * 0.98, 1'b1, -1, -1);
      wait_idle("t7f");
      expect_byte("t7_fast", 8'h55);

      // Random bytes, baud within +-2%, occasional bad stop bit.
      for (int k = 0; k < 12; k++) begin
         rb    = 8'($urandom);
         pct   = $urandom_range(980, 1020);
         rstop = ($urandom_range(0, 5) != 0);
         clear_obs();
         send_frame(rb, BP * pct / 1000.0, rstop, -1, -1);
         bus.rxd = 1'b1;
         wait_idle("rand");
         if (rstop) begin
            expect_byte("rand_good", rb);
         end else begin
            check("rand_bad_ferr", ferr_n, 1);
            check("rand_bad_no_valid", dv_q.size(), 0);
            check("rand_bad_data_held", {24'd0, bus.data_o}, {24'd0, last_good});
         end
         repeat ($urandom_range(0, 50)) step();
      end

      check("valid_ferr_exclusive", both_n, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
